// File: rtl/dfr_axil_host.sv
// dfr_axil_host: AXI4-Lite initiator that turns block commands (address,
// word count, direction) into sequential single-beat AXI-Lite transfers.
// Write data arrives on the wr_* stream; read data leaves on the rd_* stream.
// Exactly one AXI transaction is in flight at any time.
//
// Handshake rule for every channel and stream: a transfer happens on the
// rising clock edge where VALID and READY are both high; a VALID, once
// raised, holds its payload stable and is not withdrawn until that edge.
module dfr_axil_host #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 30,
    parameter int ADDR_STRIDE        = 4,
    parameter int COUNT_WIDTH        = 16
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    // command port
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [COUNT_WIDTH-1:0]          cmd_count,
    // write-data stream
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   wr_data,
    // read-data stream
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rd_data,
    // status
    output logic                            done,
    output logic                            err,
    output logic [2:0]                      dbg_state,
    // AXI4-Lite master
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_FETCH = 3'd1,
        WR_XFER  = 3'd2,
        WR_RESP  = 3'd3,
        RD_ADDR  = 3'd4,
        RD_DATA  = 3'd5,
        RD_HOLD  = 3'd6,
        DONE     = 3'd7
    } state_t;

    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] STRIDE = C_M_AXI_ADDR_WIDTH'(ADDR_STRIDE);
    localparam logic [COUNT_WIDTH-1:0]        ONE    = COUNT_WIDTH'(1);

    state_t                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [COUNT_WIDTH-1:0]          remaining_q, remaining_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                            rd_valid_q, rd_valid_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            err_q, err_d;
    logic                            aw_done, w_done;

    // An address/data channel counts as finished once its VALID has dropped
    // or its handshake is completing this cycle.
    assign aw_done = !awvalid_q || M_AXI_AWREADY;
    assign w_done  = !wvalid_q  || M_AXI_WREADY;

    // Next-state and datapath updates; everything holds by default.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        wdata_d     = wdata_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        err_d       = err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    remaining_d = cmd_count;
                    err_d       = 1'b0;
                    if (cmd_count == '0) state_d = DONE;
                    else if (cmd_write)  state_d = WR_FETCH;
                    else                 state_d = RD_ADDR;
                end
            end
            WR_FETCH: begin
                if (wr_valid) begin
                    wdata_d   = wr_data;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WR_XFER;
                end
            end
            WR_XFER: begin
                // AW and W retire independently, in either order.
                if (M_AXI_AWREADY) awvalid_d = 1'b0;
                if (M_AXI_WREADY)  wvalid_d  = 1'b0;
                if (aw_done && w_done) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    err_d       = err_q | (M_AXI_BRESP != 2'b00);
                    remaining_d = remaining_q - ONE;
                    addr_d      = addr_q + STRIDE;
                    state_d     = (remaining_q == ONE) ? DONE : WR_FETCH;
                end
            end
            RD_ADDR: begin
                if (M_AXI_ARREADY) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rd_data_d  = M_AXI_RDATA;
                    rd_valid_d = 1'b1;
                    err_d      = err_q | (M_AXI_RRESP != 2'b00);
                    state_d    = RD_HOLD;
                end
            end
            RD_HOLD: begin
                // The next AR waits here until the local consumer takes the word.
                if (rd_ready) begin
                    rd_valid_d  = 1'b0;
                    remaining_d = remaining_q - ONE;
                    addr_d      = addr_q + STRIDE;
                    state_d     = (remaining_q == ONE) ? DONE : RD_ADDR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset returns to IDLE and drops all VALIDs.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            wdata_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            wdata_q     <= wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            err_q       <= err_d;
        end
    end

    // cmd_ready is gated by reset so it stays low while reset is held.
    assign cmd_ready     = (state_q == IDLE) && M_AXI_ARESETN;
    assign wr_ready      = (state_q == WR_FETCH);
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign done          = (state_q == DONE);
    assign err           = err_q;
    assign dbg_state     = state_q;

    // The block address register drives both address channels; it only
    // advances after the response, so it is stable while either VALID is up.
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = {(C_M_AXI_DATA_WIDTH/8){1'b1}};
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state_q == WR_RESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = (state_q == RD_ADDR);
    assign M_AXI_RREADY  = (state_q == RD_DATA);

endmodule

// File: tb/tb_dfr_axil_host.sv
// Testbench for dfr_axil_host: directed block commands against a small
// AXI-Lite slave model with per-word ready delays and response codes.
module tb_dfr_axil_host;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [29:0] cmd_addr = '0;
    logic [15:0] cmd_count = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid, rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        done, err;
    logic [2:0]  dbg_state;
    logic [29:0] AWADDR, ARADDR;
    logic        AWVALID, AWREADY = 1'b0;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID, WREADY = 1'b0;
    logic [1:0]  BRESP = 2'b00;
    logic        BVALID = 1'b0, BREADY;
    logic        ARVALID, ARREADY = 1'b0;
    logic [31:0] RDATA = '0;
    logic [1:0]  RRESP = 2'b00;
    logic        RVALID = 1'b0, RREADY;

    dfr_axil_host dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_count(cmd_count),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .err(err), .dbg_state(dbg_state),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID),
        .M_AXI_WREADY(WREADY), .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID),
        .M_AXI_BREADY(BREADY), .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID),
        .M_AXI_ARREADY(ARREADY), .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP),
        .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_aw_q[$];
    logic [31:0] exp_w_q[$];
    logic [31:0] exp_ar_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_done_q[$];   // expected err value at each done pulse

    // slave / stream configuration pushed by the stimulus
    int          aw_wait_q[$];
    int          w_wait_q[$];
    int          ar_wait_q[$];
    int          rd_stall_q[$];
    logic [31:0] wr_src_q[$];
    logic [31:0] r_data_q[$];
    logic [1:0]  bresp_q[$];
    logic [1:0]  rresp_q[$];

    // handshake counters, written only by the monitor
    int wr_n = 0, aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, rd_n = 0, done_n = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // ---------------- monitor: sample mid-cycle, pop and compare ----------------
    initial begin : monitor
        logic prev_bready;
        logic prev_done;
        prev_bready = 1'b0;
        prev_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wr_valid && wr_ready) wr_n++;
                if (AWVALID && AWREADY) begin
                    aw_n++;
                    if (exp_aw_q.size() > 0) chk("awaddr", {2'b00, AWADDR}, exp_aw_q.pop_front());
                    else chk("aw_unexpected", 32'd1, 32'd0);
                end
                if (WVALID && WREADY) begin
                    w_n++;
                    chk("wstrb", {28'd0, WSTRB}, 32'hF);
                    if (exp_w_q.size() > 0) chk("wdata", WDATA, exp_w_q.pop_front());
                    else chk("w_unexpected", 32'd1, 32'd0);
                end
                if (BREADY && !prev_bready)
                    chk("bready_after_aw_and_w", {31'd0, (aw_n == b_n + 1) && (w_n == b_n + 1)}, 32'd1);
                if (BVALID && BREADY) b_n++;
                if (ARVALID && ARREADY) begin
                    ar_n++;
                    chk("no_ar_while_rd_pending", {31'd0, rd_valid}, 32'd0);
                    if (exp_ar_q.size() > 0) chk("araddr", {2'b00, ARADDR}, exp_ar_q.pop_front());
                    else chk("ar_unexpected", 32'd1, 32'd0);
                end
                if (rd_valid) begin
                    if (exp_rd_q.size() > 0) begin
                        chk("rd_data", rd_data, exp_rd_q[0]);
                        if (rd_ready) begin
                            rd_n++;
                            void'(exp_rd_q.pop_front());
                        end
                    end else begin
                        chk("rd_unexpected", 32'd1, 32'd0);
                    end
                end
                if (done) begin
                    done_n++;
                    chk("done_one_cycle", {31'd0, prev_done}, 32'd0);
                    if (exp_done_q.size() > 0) chk("err_at_done", {31'd0, err}, exp_done_q.pop_front());
                    else chk("done_unexpected", 32'd1, 32'd0);
                end
                prev_bready = BREADY;
                prev_done   = done;
            end else begin
                prev_bready = 1'b0;
                prev_done   = 1'b0;
            end
        end
    end

    // ---------------- driver: slave model and local streams, 1ns after the edge ----------------
    initial begin : bus
        int aw_cnt, w_cnt, ar_cnt, rd_cnt, wr_seen;
        logic aw_done, w_done, r_pend;
        aw_cnt = -1; w_cnt = -1; ar_cnt = -1; rd_cnt = -1; wr_seen = 0;
        aw_done = 1'b0; w_done = 1'b0; r_pend = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; ARREADY = 1'b0;
                RVALID = 1'b0; rd_ready = 1'b0; wr_valid = 1'b0;
                aw_cnt = -1; w_cnt = -1; ar_cnt = -1; rd_cnt = -1; wr_seen = wr_n;
                aw_done = 1'b0; w_done = 1'b0; r_pend = 1'b0;
                wr_src_q.delete(); aw_wait_q.delete(); w_wait_q.delete();
                ar_wait_q.delete(); rd_stall_q.delete(); bresp_q.delete();
                rresp_q.delete(); r_data_q.delete();
            end else begin
                // write-data source
                if (wr_n != wr_seen) begin
                    wr_seen  = wr_n;
                    wr_valid = 1'b0;
                end
                if (!wr_valid && wr_src_q.size() > 0) begin
                    wr_data  = wr_src_q.pop_front();
                    wr_valid = 1'b1;
                end
                // B is only raised while BREADY is up, so it completed on this edge
                if (BVALID) BVALID = 1'b0;
                if (AWREADY) begin
                    AWREADY = 1'b0;
                    aw_done = 1'b1;
                end else if (AWVALID) begin
                    if (aw_cnt < 0) aw_cnt = (aw_wait_q.size() > 0) ? aw_wait_q.pop_front() : 0;
                    if (aw_cnt == 0) begin AWREADY = 1'b1; aw_cnt = -1; end
                    else aw_cnt--;
                end
                if (WREADY) begin
                    WREADY = 1'b0;
                    w_done = 1'b1;
                end else if (WVALID) begin
                    if (w_cnt < 0) w_cnt = (w_wait_q.size() > 0) ? w_wait_q.pop_front() : 0;
                    if (w_cnt == 0) begin WREADY = 1'b1; w_cnt = -1; end
                    else w_cnt--;
                end
                if (aw_done && w_done && !BVALID) begin
                    BVALID  = 1'b1;
                    BRESP   = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
                    aw_done = 1'b0;
                    w_done  = 1'b0;
                end
                // read channels
                if (RVALID) RVALID = 1'b0;
                if (ARREADY) begin
                    ARREADY = 1'b0;
                    r_pend  = 1'b1;
                end else if (ARVALID) begin
                    if (ar_cnt < 0) ar_cnt = (ar_wait_q.size() > 0) ? ar_wait_q.pop_front() : 0;
                    if (ar_cnt == 0) begin ARREADY = 1'b1; ar_cnt = -1; end
                    else ar_cnt--;
                end
                if (r_pend && !RVALID) begin
                    RVALID = 1'b1;
                    RDATA  = (r_data_q.size() > 0) ? r_data_q.pop_front() : 32'hBAD0_BAD0;
                    RRESP  = (rresp_q.size() > 0) ? rresp_q.pop_front() : 2'b00;
                    r_pend = 1'b0;
                end
                // read-data consumer with optional stall on each word
                if (rd_valid) begin
                    if (rd_cnt < 0) rd_cnt = (rd_stall_q.size() > 0) ? rd_stall_q.pop_front() : 0;
                    if (rd_cnt == 0) rd_ready = 1'b1;
                    else begin rd_ready = 1'b0; rd_cnt--; end
                end else begin
                    rd_ready = 1'b0;
                    rd_cnt   = -1;
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [15:0] c);
        logic seen;
        seen = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a[29:0];
        cmd_count = c;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin seen = 1'b1; break; end
        end
        chk("cmd_accept", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int   start;
        logic seen;
        start = done_n;
        seen  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (done_n != start) begin seen = 1'b1; break; end
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stimulus
        int   snap;
        logic seen;

        // reset values while reset is held
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_ctrl_outputs", {23'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY, rd_valid, wr_ready, done, err}, 32'd0);
        chk("rst_awaddr", {2'b00, AWADDR}, 32'd0);
        chk("rst_araddr", {2'b00, ARADDR}, 32'd0);
        chk("rst_wdata", WDATA, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // 1) three-word write, zero-wait slave
        wr_src_q = '{32'd1, 32'd2, 32'd3};
        exp_aw_q = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008};
        exp_w_q  = '{32'd1, 32'd2, 32'd3};
        exp_done_q.push_back(32'd0);
        repeat (2) @(posedge clk);
        send_cmd(1'b1, 32'h0040_0000, 16'd3);
        @(negedge clk);
        chk("fetch_cycle_wr_ready_no_aw", {30'd0, wr_ready, AWVALID}, 32'd2);
        @(negedge clk);
        chk("aw_w_rise_together", {30'd0, AWVALID, WVALID}, 32'd3);
        wait_done("write_block_done");

        // 2) two-word read, AR delayed 3 cycles, first word stalled 5 cycles
        ar_wait_q  = '{3, 0};
        r_data_q   = '{32'h1111_2222, 32'h3333_4444};
        rd_stall_q = '{5, 0};
        exp_ar_q   = '{32'h0080_0010, 32'h0080_0014};
        exp_rd_q   = '{32'h1111_2222, 32'h3333_4444};
        exp_done_q.push_back(32'd0);
        send_cmd(1'b0, 32'h0080_0010, 16'd2);
        wait_done("read_block_done");
        chk("read_words_consumed", rd_n, 32'd2);

        // 3) channel skew: W first, then AW first, then both together
        wr_src_q  = '{32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2};
        aw_wait_q = '{4, 0, 0};
        w_wait_q  = '{0, 3, 0};
        exp_aw_q  = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008};
        exp_w_q   = '{32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2};
        exp_done_q.push_back(32'd0);
        snap = aw_n;
        send_cmd(1'b1, 32'h0000_1000, 16'd3);
        wait_done("skew_block_done");
        chk("skew_one_aw_per_word", aw_n - snap, 32'd3);

        // 4) error on second of three writes; block still completes
        wr_src_q = '{32'd7, 32'd8, 32'd9};
        bresp_q  = '{2'b00, 2'b10, 2'b00};
        exp_aw_q = '{32'h0000_2000, 32'h0000_2004, 32'h0000_2008};
        exp_w_q  = '{32'd7, 32'd8, 32'd9};
        exp_done_q.push_back(32'd1);
        snap = b_n;
        send_cmd(1'b1, 32'h0000_2000, 16'd3);
        wait_done("error_block_done");
        chk("error_all_b_responses", b_n - snap, 32'd3);
        @(negedge clk);
        chk("err_sticky_after_done", {31'd0, err}, 32'd1);

        // 5) zero-count write: done next cycle, err cleared on accept, no AXI traffic
        exp_done_q.push_back(32'd0);
        snap = aw_n + w_n + ar_n;
        send_cmd(1'b1, 32'h0000_3000, 16'd0);
        @(negedge clk);
        chk("zero_count_done_next_cycle", {31'd0, done}, 32'd1);
        chk("err_cleared_on_accept", {31'd0, err}, 32'd0);
        repeat (4) @(negedge clk);
        chk("zero_count_no_axi", aw_n + w_n + ar_n - snap, 32'd0);

        // 6) reset while AWVALID is high, then a fresh one-word write
        wr_src_q  = '{32'hDEAD_0001, 32'hDEAD_0002};
        aw_wait_q = '{20};
        w_wait_q  = '{20};
        send_cmd(1'b1, 32'h0000_5000, 16'd2);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (AWVALID) begin seen = 1'b1; break; end
        end
        chk("awvalid_before_reset", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_drops_valids", {26'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY, rd_valid}, 32'd0);
        chk("reset_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {28'd0, cmd_ready, dbg_state}, 32'h8);
        wr_src_q.push_back(32'h1234_5678);
        exp_aw_q.push_back(32'h0000_6000);
        exp_w_q.push_back(32'h1234_5678);
        exp_done_q.push_back(32'd0);
        send_cmd(1'b1, 32'h0000_6000, 16'd1);
        wait_done("post_reset_block_done");

        // nothing expected may be left over
        repeat (5) @(posedge clk);
        chk("scoreboard_drained",
            exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_rd_q.size() + exp_done_q.size(),
            32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
